instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the control unit's IR load path.
- Reads variable-address bytes from the byte-wide program RAM and assembles fixed 3-byte instructions: opcode, Operando1, Operando2.
- Buffers assembled instructions in a small queue.
- Presents them to the control unit over a valid/ready handshake, and supports a PC redirect (jump/branch) with flush.

---
 rtl/instruction_fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetches 3-byte instructions (opcode, operand 1, operand 2) from a byte-wide program RAM,
// queues them, and hands them to the control unit over valid/ready, with PC redirect + flush.
module instruction_fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_op1,
  output logic [7:0]        instr_op2,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int SLOT_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD0  = 2'd1,
    S_RD1  = 2'd2,
    S_RD2  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [7:0]        op1;
    logic [7:0]        op2;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [7:0]        byte1_q, byte1_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  entry_t            q_mem [QUEUE_DEPTH];
  entry_t            head;
  entry_t            push_entry;
  logic              push;
  logic              pop;
  logic              in_flight;
  logic [SLOT_W-1:0] slots_used;
  logic [SLOT_W-1:0] slots_after_pop;
  logic              may_start;
  logic [ADDR_W-1:0] addr_off;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and slot accounting
  // ---------------------------------------------------------------------------
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign push        = pend_q & ~redirect;

  // An instruction reserves its queue slot from RD1 until its byte2 lands.
  assign in_flight       = (state_q == S_RD1) || (state_q == S_RD2) || pend_q;
  assign slots_used      = SLOT_W'(count_q) + SLOT_W'(in_flight);
  assign slots_after_pop = slots_used - SLOT_W'(pop);
  assign may_start       = (slots_after_pop < SLOT_W'(QUEUE_DEPTH));

  assign push_entry = '{opcode: byte0_q, op1: byte1_q, op2: mem_rdata, pc: pend_pc_q};
  assign head       = q_mem[rd_ptr_q];

  // Head fields read as zero while empty, so the unreset storage never leaks out.
  assign instr_opcode = instr_valid ? head.opcode : '0;
  assign instr_op1    = instr_valid ? head.op1    : '0;
  assign instr_op2    = instr_valid ? head.op2    : '0;
  assign instr_pc     = instr_valid ? head.pc     : '0;
  assign fetch_pc     = fetch_pc_q;
  assign mem_addr     = fetch_pc_q + addr_off;

  // ---------------------------------------------------------------------------
  // FSM: next state and read-port outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    mem_rd   = 1'b0;
    addr_off = '0;
    case (state_q)
      S_IDLE: state_d = may_start ? S_RD0 : S_IDLE;
      S_RD0: begin
        mem_rd  = 1'b1;
        state_d = S_RD1;
      end
      S_RD1: begin
        mem_rd   = 1'b1;
        addr_off = ADDR_W'(1);
        state_d  = S_RD2;
      end
      S_RD2: begin
        mem_rd   = 1'b1;
        addr_off = ADDR_W'(2);
        state_d  = may_start ? S_RD0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      state_d = S_RD0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (state_q == S_RD1) begin
        byte0_d = mem_rdata;
      end
      if (state_q == S_RD2) begin
        byte1_d    = mem_rdata;
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(3);
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      byte0_q    <= '0;
      byte1_q    <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count_q alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a RAM model feeds the DUT, a scoreboard of
// predicted instructions is compared at every accepted handshake, plus directed timing checks.
module tb_instruction_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [7:0]        instr_opcode;
  logic [7:0]        instr_op1;
  logic [7:0]        instr_op2;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] fetch_pc;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] pc;
  } exp_t;

  logic [7:0] ram [256];
  exp_t       sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_accept = 0;

  instruction_fetch_unit #(.ADDR_W(ADDR_W), .QUEUE_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op1    (instr_op1),
    .instr_op2    (instr_op2),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fetch_pc     (fetch_pc)
  );

  always #5 clk = ~clk;

  // Program RAM: data returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Replace the scoreboard with the instruction stream expected from start_pc onward.
  task automatic predict(input logic [7:0] start_pc, input int n);
    logic [7:0] pc;
    exp_t       e;
    pc = start_pc;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.opcode = ram[pc];
      e.op1    = ram[pc + 8'd1];
      e.op2    = ram[pc + 8'd2];
      e.pc     = pc;
      sb.push_back(e);
      pc = pc + 8'd3;
    end
  endtask

  function automatic logic [31:0] head_word();
    return {instr_opcode, instr_op1, instr_op2, instr_pc};
  endfunction

  // Scoreboard monitor: every accepted instruction must match the next prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && instr_valid && instr_ready && !redirect) begin
      n_accept++;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("accepted_instr", head_word(), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wrap_addr [4];
    int         a0;

    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    ram[0] = 8'hA1; ram[1] = 8'h11; ram[2] = 8'h22;
    ram[3] = 8'hB2; ram[4] = 8'h33; ram[5] = 8'h44;

    // Reset state
    repeat (3) tick();
    check("rst_mem_rd",   mem_rd,       0);
    check("rst_mem_addr", mem_addr,     0);
    check("rst_valid",    instr_valid,  0);
    check("rst_opcode",   instr_opcode, 0);
    check("rst_op1",      instr_op1,    0);
    check("rst_op2",      instr_op2,    0);
    check("rst_pc",       instr_pc,     0);
    check("rst_fetch_pc", fetch_pc,     0);

    // Streaming from address 0 with ready held high
    predict(8'h00, 40);
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 6) begin
        check("t1_mem_rd",   mem_rd,   1);
        check("t1_mem_addr", mem_addr, k);
      end
      check("t1_valid", instr_valid, (k == 4 || k == 7) ? 1 : 0);
      if (k == 4) check("t1_first",  head_word(), 32'hA1112200);
      if (k == 7) check("t1_second", head_word(), 32'hB2334403);
    end

    // Back-pressure: queue fills to DEPTH, fetch stops, head stays put
    instr_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t2_valid", instr_valid, 1);
      check("t2_head_stable", head_word(), 32'hB2334403);
      if (i >= 1) check("t2_no_read", mem_rd, 0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("t2_refetch_rd",   mem_rd,   1);
    check("t2_refetch_addr", mem_addr, 9);
    check("t2_next_head",    instr_pc, 6);

    // Redirect while in RD1 with one entry queued; the same-cycle pop is ignored
    tick();
    check("t3_in_rd1", mem_addr, 10);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    instr_ready = 1'b1;
    predict(8'h40, 40);
    tick();
    redirect = 1'b0;
    check("t3_flushed",  instr_valid, 0);
    check("t3_mem_rd",   mem_rd,      1);
    check("t3_mem_addr", mem_addr,    8'h40);
    check("t3_fetch_pc", fetch_pc,    8'h40);
    for (int k = 1; k < 5; k++) begin
      tick();
      check("t3_valid", instr_valid, (k == 4) ? 1 : 0);
    end
    check("t3_first", head_word(), {ram[8'h40], ram[8'h41], ram[8'h42], 8'h40});

    // Address wrap-around at the top of memory
    ram[8'hFE] = 8'hC3; ram[8'hFF] = 8'h01; ram[8'h00] = 8'h02;
    wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00; wrap_addr[3] = 8'h01;
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    predict(8'hFE, 40);
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (k < 4) check("t4_mem_addr", mem_addr, wrap_addr[k]);
      if (k == 3) check("t4_fetch_pc", fetch_pc, 8'h01);
    end
    check("t4_wrap_instr", head_word(), 32'hC30102FE);

    // Mixed ready pattern: push and pop overlap, FIFO order checked by the scoreboard
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    predict(8'h10, 40);
    tick();
    redirect = 1'b0;
    a0 = n_accept;
    for (int i = 0; i < 90; i++) begin
      instr_ready = (i % 4 != 3);
      tick();
    end
    check("t6_accepted_ge_10", 32'((n_accept - a0) >= 10), 32'd1);

    // Asynchronous reset during RD2 with an entry queued
    redirect    = 1'b1;
    redirect_pc = 8'h80;
    instr_ready = 1'b0;
    predict(8'h80, 40);
    tick();
    redirect = 1'b0;
    repeat (5) tick();
    check("t5_in_rd2",  mem_addr,    8'h85);
    check("t5_queued",  instr_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid",    instr_valid,  0);
    check("t5_async_mem_rd",   mem_rd,       0);
    check("t5_async_fetch_pc", fetch_pc,     0);
    check("t5_async_mem_addr", mem_addr,     0);
    check("t5_async_opcode",   instr_opcode, 0);
    check("t5_async_pc",       instr_pc,     0);
    predict(8'h00, 40);
    tick();
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        check("t5_restart_rd",   mem_rd,   1);
        check("t5_restart_addr", mem_addr, 0);
      end
      check("t5_valid", instr_valid, (k == 4) ? 1 : 0);
    end
    check("t5_first", head_word(), 32'h02112200);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
